apb_wrr_arbiter: RTL

- Weighted round-robin arbiter that shares one APB slave port between NUM_APB_MASTERS requesters.
- Sits beside the APB master mux. It takes master PSEL requests and slave completion, and produces a registered one-hot grant that drives the mux select.
- Each granted master may complete up to its programmed weight of back-to-back transfers before priority rotates.
- Grant is held for a whole APB transfer (SETUP+ACCESS) and released on completion.

---
 rtl/apb_wrr_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/apb_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_wrr_arbiter
//
// Weighted round-robin arbiter that shares one APB slave port between
// NUM_APB_MASTERS requesters. It produces a one-hot grant that drives the
// select of the APB master mux. The grant is held for a whole APB transfer
// (SETUP + ACCESS) and released on completion. A granted master may complete
// up to its programmed weight of back-to-back transfers before priority
// rotates to the next requester. There is always at least one idle cycle
// between two grants.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to enable a per-grant watchdog.
// The watchdog aborts a grant that has not completed after TIMEOUT_CYCLES
// cycles and pulses timeout_o. Without the macro there is no watchdog, a
// grant holds indefinitely, and timeout_o is tied to 0.
//
// Ports:
//   PCLK         in   clock, all logic on the rising edge
//   PRESET       in   synchronous active-high reset
//   req_i        in   per-master request (master PSEL)
//   weight_i     in   packed per-master weights, master i at
//                     [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; sampled at grant time
//   xfer_done_i  in   completion of the granted transfer
//                     (PSEL_m & PENABLE_m & PREADY_m)
//   gnt_o        out  one-hot grant, all-zero when idle
//   gnt_idx_o    out  binary index of the granted master, 0 when idle
//   gnt_valid_o  out  OR of gnt_o
//   timeout_o    out  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module apb_wrr_arbiter #(
    parameter int NUM_APB_MASTERS = 16,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                    PCLK,
    input  logic                                    PRESET,
    input  logic [NUM_APB_MASTERS-1:0]              req_i,
    input  logic [NUM_APB_MASTERS*WEIGHT_WIDTH-1:0] weight_i,
    input  logic                                    xfer_done_i,
    output logic [NUM_APB_MASTERS-1:0]              gnt_o,
    output logic [$clog2(NUM_APB_MASTERS)-1:0]      gnt_idx_o,
    output logic                                    gnt_valid_o,
    output logic                                    timeout_o
);

    localparam int IDX_W = $clog2(NUM_APB_MASTERS);

    if (NUM_APB_MASTERS < 2) begin : g_bad_masters
        $error("apb_wrr_arbiter: NUM_APB_MASTERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_wrr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        ptr, ptr_nxt;
    logic [IDX_W-1:0]        last, last_nxt;
    logic [WEIGHT_WIDTH-1:0] credit, credit_nxt;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] watchdog, watchdog_nxt;
    logic            timeout_q, timeout_nxt;
`endif

    // First requester found scanning start, start+1, ... modulo the master
    // count. Scanning downwards lets the smallest offset overwrite the others.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_APB_MASTERS-1:0] req,
        input logic [IDX_W-1:0]           start
    );
        logic [IDX_W-1:0] pick;
        int               cand;
        pick = start;
        for (int i = NUM_APB_MASTERS - 1; i >= 0; i--) begin
            cand = (int'(start) + i) % NUM_APB_MASTERS;
            if (req[cand]) pick = IDX_W'(cand);
        end
        return pick;
    endfunction

    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        winner_next_ptr;
    logic [WEIGHT_WIDTH-1:0] winner_weight;
    logic [WEIGHT_WIDTH-1:0] winner_credit;

    always_comb begin
        winner          = rr_pick(req_i, ptr);
        winner_next_ptr = IDX_W'((int'(winner) + 1) % NUM_APB_MASTERS);
        winner_weight   = weight_i[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        // A weight of 0 behaves as 1, so the remaining credit is 0 either way.
        winner_credit   = (winner_weight == '0) ? '0 : winner_weight - 1'b1;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            last      <= '0;
            credit    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            watchdog  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            last      <= last_nxt;
            credit    <= credit_nxt;
`ifdef APB_ARB_TIMEOUT_EN
            watchdog  <= watchdog_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        last_nxt   = last;
        credit_nxt = credit;
`ifdef APB_ARB_TIMEOUT_EN
        watchdog_nxt = '0;
        timeout_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (credit != '0 && req_i[last]) begin
                    // Same master continues its weighted burst; ptr is already past it.
                    state_nxt  = GRANT;
                    credit_nxt = credit - 1'b1;
                end else if (|req_i) begin
                    state_nxt  = GRANT;
                    last_nxt   = winner;
                    ptr_nxt    = winner_next_ptr;
                    credit_nxt = winner_credit;
                end else begin
                    credit_nxt = '0;
                end
            end
            GRANT: begin
                if (xfer_done_i) begin
                    // Normal completion keeps the credit for a possible regrant.
                    state_nxt = IDLE;
                end else if (!req_i[last]) begin
                    // Master abandoned its request: end the burst.
                    state_nxt  = IDLE;
                    credit_nxt = '0;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = IDLE;
                    credit_nxt  = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    watchdog_nxt = watchdog + 1'b1;
                end
`endif
            end
        endcase
    end

    // Outputs decode registered state only, so inputs never reach them
    // combinationally.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        if (state == GRANT) begin
            gnt_o[last] = 1'b1;
            gnt_idx_o   = last;
            gnt_valid_o = 1'b1;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
